flit_tx_arbiter: RTL and testbench

//  Round-robin arbiter sharing one flit transmit channel between NUM_REQ packet sources.

---
 rtl/flit_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_flit_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one flit transmit channel between
// NUM_REQ sources. A stall watchdog reclaims the channel from a source that goes silent.
module flit_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int FLIT_WIDTH  = 64,
    parameter int STALL_LIMIT = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [FLIT_WIDTH-1:0]         out_flit,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          stall_err
);

    localparam int GID_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [GID_W-1:0]   last_grant_q, last_grant_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               stall_err_q, stall_err_d;

    logic [GID_W-1:0]   pick;
    logic               pick_found;
    logic [GID_W-1:0]   scan_idx;
    logic [CNT_W-1:0]   stall_inc;

    logic [FLIT_WIDTH-1:0] flit_arr [NUM_REQ];
    logic                  g_valid;
    logic                  g_last;
    logic [FLIT_WIDTH-1:0] g_flit;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign flit_arr[i] = req_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
    end

    // Rotating priority: the source after the previous owner is scanned first.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        scan_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = GID_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick       = scan_idx;
            end
        end
    end

    always_comb begin
        g_valid = req_valid[grant_id_q];
        g_last  = req_last[grant_id_q];
        g_flit  = flit_arr[grant_id_q];
    end

    assign stall_inc = stall_cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        stall_cnt_d  = stall_cnt_q;
        stall_err_d  = stall_err_q;
        req_ready    = '0;
        out_valid    = 1'b0;
        out_flit     = '0;
        out_last     = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall_cnt_d = '0;
                if (pick_found) begin
                    state_d    = S_GRANT;
                    grant_id_d = pick;
                end
            end
            S_GRANT: begin
                out_valid             = g_valid;
                out_flit              = g_flit;
                out_last              = g_last;
                req_ready[grant_id_q] = out_ready;
                if (g_valid) begin
                    // Backpressure from the transmitter is not silence.
                    stall_cnt_d = '0;
                    if (out_ready && g_last) begin
                        state_d      = S_IDLE;
                        last_grant_d = grant_id_q;
                    end
                end else if (stall_inc == CNT_W'(STALL_LIMIT)) begin
                    state_d      = S_IDLE;
                    last_grant_d = grant_id_q;
                    stall_err_d  = 1'b1;
                    stall_cnt_d  = '0;
                end else begin
                    stall_cnt_d = stall_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GID_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            stall_cnt_q  <= '0;
            stall_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            stall_cnt_q  <= stall_cnt_d;
            stall_err_q  <= stall_err_d;
        end
    end

    assign busy      = (state_q == S_GRANT);
    assign grant_id  = grant_id_q;
    assign stall_err = stall_err_q;

endmodule

// File: tb/tb_flit_tx_arbiter.sv
// Bench for flit_tx_arbiter: directed scenarios pinned with literal values, then random
// packet traffic checked every cycle against a behavioural ownership model.
module tb_flit_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int SL = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   rv;
    logic [N-1:0]   rl;
    logic [W-1:0]   rf [N];
    logic [N*W-1:0] req_flit;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_flit;
    logic           out_last;
    logic           out_ready;
    logic [1:0]     grant_id;
    logic           busy;
    logic           stall_err;

    always #5 clk = ~clk;

    assign req_flit = {rf[3], rf[2], rf[1], rf[0]};

    flit_tx_arbiter #(.NUM_REQ(N), .FLIT_WIDTH(W), .STALL_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(rv), .req_flit(req_flit), .req_last(rl), .req_ready(req_ready),
        .out_valid(out_valid), .out_flit(out_flit), .out_last(out_last),
        .out_ready(out_ready), .grant_id(grant_id), .busy(busy), .stall_err(stall_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: who owns the channel (-1 = nobody), who owned it last, silent cycles, sticky error.
    int       m_owner;
    int       m_last;
    int       m_sil;
    bit       m_err;
    bit [N-1:0] m_xfer;

    int s_left [N];
    int s_pkt  [N];
    int s_mute [N];
    bit s_act  [N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_sil   = 0;
        m_err   = 1'b0;
        m_xfer  = '0;
    endtask

    task automatic model_step();
        bit found;
        m_xfer = '0;
        if (rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!found && rv[(m_last + k) % N]) begin
                    found   = 1'b1;
                    m_owner = (m_last + k) % N;
                end
            end
        end else if (rv[m_owner]) begin
            m_sil = 0;
            if (out_ready) begin
                m_xfer[m_owner] = 1'b1;
                if (rl[m_owner]) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end else begin
            m_sil++;
            if (m_sil == SL) begin
                m_last  = m_owner;
                m_owner = -1;
                m_err   = 1'b1;
                m_sil   = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic         e_busy, e_ov, e_last;
        logic [W-1:0] e_flit;
        logic [N-1:0] e_rdy;
        e_busy = 1'b0; e_ov = 1'b0; e_last = 1'b0; e_flit = '0; e_rdy = '0;
        if (m_owner >= 0) begin
            e_busy = 1'b1;
            e_ov   = rv[m_owner];
            e_last = rl[m_owner];
            e_flit = rf[m_owner];
            e_rdy  = out_ready ? (N'(1) << m_owner) : '0;
            chk("grant_id", grant_id, m_owner);
        end
        chk("busy", busy, e_busy);
        chk("out_valid", out_valid, e_ov);
        chk("out_last", out_last, e_last);
        chk("out_flit", out_flit, e_flit);
        chk("req_ready", req_ready, e_rdy);
        chk("stall_err", stall_err, m_err);
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic tick();
        if (rst) model_reset();
        #1;
        compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic rst_pulse();
        rv = '0; rl = '0; out_ready = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rv = '0; rl = '0; out_ready = 1'b1;
        for (int i = 0; i < N; i++) rf[i] = '0;
        model_reset();
        @(negedge clk);

        // Reset held with every source requesting
        rv = '1; rl = '1;
        for (int i = 0; i < N; i++) rf[i] = 64'h100 + 64'(i);
        tick(); tick();
        #1;
        chk("t1_busy", busy, 0);
        chk("t1_ready", req_ready, 0);
        chk("t1_ovalid", out_valid, 0);
        chk("t1_err", stall_err, 0);
        rv = '0; rl = '0; rst = 1'b0;
        tick();

        // Single source, three-flit packet
        rv = 4'b0100; rf[2] = 64'hA1;
        tick();
        #1;
        chk("t2_busy", busy, 1);
        chk("t2_gid", grant_id, 2);
        chk("t2_flit1", out_flit, 64'hA1);
        chk("t2_ready", req_ready, 4'b0100);
        tick();
        rf[2] = 64'hA2;
        #1 chk("t2_flit2", out_flit, 64'hA2);
        tick();
        rf[2] = 64'hA3; rl[2] = 1'b1;
        #1 chk("t2_last", out_last, 1);
        tick();
        rv = '0; rl = '0;
        #1 chk("t2_release", busy, 0);
        tick();

        // Round robin after reset: 0,1,2,3,0 with an idle cycle between
        rst_pulse();
        rv = '1; rl = '1;
        for (int i = 0; i < N; i++) rf[i] = 64'h300 + 64'(i);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("t3_busy", busy, 64'(c % 2));
            if (c % 2 == 1) chk("t3_order", grant_id, 64'((c / 2) % 4));
            tick();
        end
        rv = '0; rl = '0;
        tick();

        // Backpressure for 50 cycles on source 1
        rst_pulse();
        rv = 4'b0010; rl = 4'b0010; rf[1] = 64'hB0B; out_ready = 1'b0;
        tick();
        for (int c = 0; c < 50; c++) begin
            #1 chk("t4_hold", out_flit, 64'hB0B);
            tick();
        end
        #1;
        chk("t4_noerr", stall_err, 0);
        chk("t4_busy", busy, 1);
        out_ready = 1'b1;
        #1 chk("t4_ready", req_ready, 4'b0010);
        tick();
        rv = '0; rl = '0;
        #1 chk("t4_done", busy, 0);
        tick();

        // Watchdog: source 0 goes silent mid-packet, source 1 waiting
        rst_pulse();
        rv = 4'b0011; rl = 4'b0010; rf[0] = 64'hC0; rf[1] = 64'hC1;
        tick();
        #1 chk("t5_gid0", grant_id, 0);
        tick();
        rv[0] = 1'b0;
        repeat (SL - 1) tick();
        #1;
        chk("t5_still_busy", busy, 1);
        chk("t5_no_err_yet", stall_err, 0);
        tick();
        #1;
        chk("t5_released", busy, 0);
        chk("t5_err", stall_err, 1);
        tick();
        #1;
        chk("t5_next_gid", grant_id, 1);
        chk("t5_next_busy", busy, 1);
        tick();
        rv = '0; rl = '0;
        tick();
        #1 chk("t5_sticky", stall_err, 1);

        // Reset in the middle of a four-flit packet
        rst_pulse();
        rv = 4'b0100; rf[2] = 64'hD1;
        tick(); tick();
        rf[2] = 64'hD2;
        #1 chk("t6_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_ovalid", out_valid, 0);
        chk("t6_flit", out_flit, 0);
        tick();
        rst = 1'b0; rv = 4'b0101; rf[0] = 64'hE0; rl = 4'b0001;
        tick();
        #1;
        chk("t6_gid", grant_id, 0);
        chk("t6_busy2", busy, 1);
        tick();
        rv = '0; rl = '0;
        tick();

        // Random packet traffic with occasional silence, backpressure and reset
        rst_pulse();
        for (int i = 0; i < N; i++) begin
            s_act[i] = 1'b0; s_left[i] = 0; s_pkt[i] = 0; s_mute[i] = 0;
        end
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_xfer[i]) begin
                    s_left[i]--;
                    if (s_left[i] == 0) s_act[i] = 1'b0;
                    else rf[i] = {8'(i), 24'(s_pkt[i]), 32'($urandom())};
                end
                if (!s_act[i] && ($urandom() % 4 == 0)) begin
                    s_act[i]  = 1'b1;
                    s_left[i] = int'($urandom_range(1, 5));
                    s_pkt[i]++;
                    rf[i] = {8'(i), 24'(s_pkt[i]), 32'($urandom())};
                end
                if (s_act[i] && s_mute[i] == 0 && ($urandom() % 150 == 0))
                    s_mute[i] = int'($urandom_range(20, 45));
                rv[i] = s_act[i] && (s_mute[i] == 0) && ($urandom() % 10 != 0);
                if (s_mute[i] > 0) s_mute[i]--;
                rl[i] = s_act[i] && (s_left[i] == 1);
            end
            out_ready = ($urandom() % 4 != 0);
            rst = ($urandom() % 500 == 0);
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    s_act[i] = 1'b0; s_mute[i] = 0;
                end
                rv = '0; rl = '0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
